uart_rx_packer: RTL and testbench
=================================

# uart_rx_packer

Byte-to-word packer sitting directly downstream of the UART receiver. It takes each received byte, signalled by the receiver's `load` level and its 32-bit zero-extended data bus, and packs four consecutive bytes little-endian into one 32-bit word. Each word is presented on a valid/ready interface toward the bus or register side. An optional idle timeout flushes partially filled words.

## Interface
Parameters:
- `TIMEOUT`, default 40: number of `enable` ticks without a new byte before a partial word is flushed. Range 1..65535. Used only with `UART_RX_PACK_TIMEOUT_EN`.

Ports:
- `clk`  input  1  system clock; the single clock of the block.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  baud tick shared with the receiver. Used only by the timeout counter.
- `rx_load`  input  1  receiver byte-ready level. It may stay high for many `clk` cycles.
- `rx_data`  input  32  receiver data. Only `[7:0]` is used; `[31:8]` is ignored.
- `word_out`  output  32  packed word. Byte 0 is in `[7:0]`; unfilled bytes read 0.
- `word_valid`  output  1  `word_out` holds an unconsumed word.
- `word_ready`  input  1  consumer accepts the word on any `clk` edge where `word_valid` and `word_ready` are both high.
- `byte_cnt`  output  3  number of valid bytes in `word_out`, 1..4 while `word_valid` is high.
- `overrun`  output  1  one-`clk` pulse when a received byte is dropped.

## Operation
- Byte detection: register `load_d` samples `rx_load` every `clk`. A byte event is `rise = rx_load & ~load_d`, so exactly one event occurs per `rx_load` high period. `rx_data[7:0]` is sampled in the same cycle as `rise`.
- Assembly: register `asm[31:0]` and count `acnt[2:0]` (0..4). On each `rise` with `acnt < 4`, the byte is written to `asm[8*acnt +: 8]` and `acnt` increments.
- The output slot is free when `!word_valid || word_ready`.
- Transfer: a transfer occurs when `acnt` would reach 4 (the fourth byte arrives this cycle) or `acnt == 4` already holds, and the slot is free. On transfer:
  - `word_out` is loaded with the complete word.
  - `byte_cnt` is set to 4 and `word_valid` is set to 1.
  - `asm` and `acnt` clear to 0.
- Full assembly with the slot busy: `acnt` is held at 4 and `asm` is held, pending transfer.
- Overrun: a `rise` while `acnt == 4` drops the byte, pulses `overrun` for one cycle, and leaves `asm` unchanged.
- Simultaneous events:
  - A handshake and a transfer in the same cycle: `word_valid` stays 1 and `word_out` takes the new word.
  - A handshake with no transfer: `word_valid` clears to 0.
- States, derived from `acnt` and `word_valid`:
  - EMPTY: `acnt == 0`.
  - FILLING: `acnt` is 1..3.
  - PENDING: `acnt == 4` and `word_valid == 1`.
  - Transitions follow the rules above.
- Reset (asserted at any time, including mid-word): `word_out` = 0, `word_valid` = 0, `byte_cnt` = 0, `overrun` = 0, `asm` = 0, `acnt` = 0, `load_d` = 0, timeout counter = 0. A partial word or pending word is discarded.
- If `rx_load` is already high when reset is released, it produces one `rise` on the first active cycle.

## Timing
- Latency: if `rx_load` is first sampled high at edge k and it is the fourth byte with the slot free, then `word_valid` and `word_out` update at edge k. Total latency from the `rx_load` rising level is one `clk`.
- `word_out` and `byte_cnt` are stable while `word_valid` is high and no handshake occurs.
- `overrun` is asserted at the edge that samples the dropping `rise` and deasserts at the next edge.
- All outputs are registered; there is no combinational path from `word_ready` to any output.

## Configuration
- `UART_RX_PACK_TIMEOUT_EN` defined:
  - A 16-bit counter increments on each `enable` tick while `acnt` is 1..3.
  - The counter clears on `rise`, on any transfer, or when `acnt` is 0.
  - When the count reaches `TIMEOUT` and the slot is free, the partial word is transferred: `word_out` = `asm` with unfilled bytes zero, `byte_cnt` = `acnt`. `asm`, `acnt` and the counter clear.
  - If the slot is busy, the flush waits until the slot is free. A `rise` arriving in the same cycle as the flush is appended to the word first.
- Not defined:
  - There is no counter and partial words are held indefinitely.
  - `byte_cnt` is always 4 when `word_valid` is high. `TIMEOUT` is ignored.

## Test plan
- Four bytes 0x11, 0x22, 0x33, 0x44 with `word_ready`=1 -> one `word_valid` cycle, `word_out`=0x44332211, `byte_cnt`=4, `overrun` never asserted.
- `rx_load` held high for 30 `clk` per byte, one byte 0xA5 -> `acnt` = 1 and no duplicate capture.
- `word_ready`=0, eight bytes 0x01..0x08 followed by a ninth byte 0x09 -> first word 0x04030201 held, `overrun` pulses once on 0x09. After `word_ready`=1, the words 0x04030201 then 0x08070605 are delivered.
- Handshake in the same cycle as a fourth-byte transfer -> `word_valid` stays 1 and the new word appears on the following cycle with no gap.
- Reset asserted after two bytes, then bytes 0xAA..0xDD -> all outputs 0 during reset, then `word_out`=0xDDCCBBAA.
- With `UART_RX_PACK_TIMEOUT_EN` and `TIMEOUT`=40: two bytes 0x5A, 0xC3, then 40 `enable` ticks idle -> `word_out`=0x0000C35A, `byte_cnt`=2. Without the macro, no output appears.

Source files
------------

// File: rtl/uart_rx_packer.sv
// Packs four received UART bytes little-endian into 32-bit words on a valid/ready port.
// Define UART_RX_PACK_TIMEOUT_EN to flush partial words after TIMEOUT idle enable ticks.
module uart_rx_packer #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx_load,
  input  logic [31:0] rx_data,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [2:0]  byte_cnt,
  output logic        overrun
);

  logic        load_d_reg;
  logic [31:0] asm_reg;
  logic [31:0] asm_next;
  logic [2:0]  acnt_reg;
  logic [2:0]  acnt_next;
  logic        rise;
  logic        capture;
  logic        drop;
  logic        slot_free;
  logic        full_xfer;
  logic        flush;
  logic        xfer;

  // One byte event per rx_load high period, however long the level is held.
  assign rise      = rx_load & ~load_d_reg;
  assign capture   = rise && (acnt_reg < 3'd4);
  assign drop      = rise && (acnt_reg == 3'd4);
  assign slot_free = !word_valid || word_ready;
  assign acnt_next = capture ? acnt_reg + 3'd1 : acnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign asm_next[8*gi +: 8] = (capture && (acnt_reg == 3'(gi))) ? rx_data[7:0]
                                                                     : asm_reg[8*gi +: 8];
    end
  endgenerate

  assign full_xfer = (acnt_next == 3'd4) && slot_free;
  assign xfer      = full_xfer || flush;

`ifdef UART_RX_PACK_TIMEOUT_EN
  logic [15:0] tcnt_reg;
  logic        partial;
  logic        unused_bits;

  assign partial     = (acnt_reg != 3'd0) && (acnt_reg != 3'd4);
  // A byte arriving in the flush cycle is already folded into asm_next/acnt_next.
  assign flush       = (tcnt_reg >= 16'(TIMEOUT)) && (acnt_next != 3'd0) && slot_free;
  assign unused_bits = ^rx_data[31:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_reg <= '0;
    end else if (rise || xfer || (acnt_reg == 3'd0)) begin
      tcnt_reg <= '0;
    end else if (enable && partial && (tcnt_reg < 16'(TIMEOUT))) begin
      tcnt_reg <= tcnt_reg + 16'd1;
    end
  end
`else
  logic unused_bits;

  assign flush       = 1'b0;
  assign unused_bits = ^{rx_data[31:8], enable};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_d_reg <= 1'b0;
      asm_reg    <= '0;
      acnt_reg   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      byte_cnt   <= '0;
      overrun    <= 1'b0;
    end else begin
      load_d_reg <= rx_load;
      overrun    <= drop;
      if (xfer) begin
        // asm clears on every transfer, so unfilled bytes of a partial word are already zero.
        word_out   <= asm_next;
        byte_cnt   <= acnt_next;
        word_valid <= 1'b1;
        asm_reg    <= '0;
        acnt_reg   <= '0;
      end else begin
        if (word_valid && word_ready) begin
          word_valid <= 1'b0;
        end
        asm_reg  <= asm_next;
        acnt_reg <= acnt_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed and randomized checks of uart_rx_packer against a byte/word queue model.
module tb_uart_rx_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rx_load = 1'b0;
  logic [31:0] rx_data = '0;
  logic        word_ready = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic [2:0]  byte_cnt;
  logic        overrun;

  int compared = 0;
  int mismatched = 0;

  // Reference model: assembly bytes, one held output word, expected deliveries.
  logic [7:0]  asm_q[$];
  bit          stalled = 0;
  bit          out_full = 0;
  logic [31:0] out_word = '0;
  logic [31:0] exp_w[$];
  int          exp_c[$];
  logic [31:0] got_w[$];
  int          got_c[$];
  int          ovr_exp = 0;
  int          ovr_seen = 0;
  int          valid_cycles = 0;

  always #5 clk = ~clk;

  uart_rx_packer #(.TIMEOUT(40)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rx_load   (rx_load),
    .rx_data   (rx_data),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .byte_cnt  (byte_cnt),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] asm_word();
    logic [31:0] w;
    w = '0;
    foreach (asm_q[i]) w = w | (32'(asm_q[i]) << (8 * i));
    return w;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (asm_q.size() == 4) begin
      ovr_exp++;
      return;
    end
    asm_q.push_back(b);
    if (asm_q.size() == 4) begin
      if (!stalled) begin
        exp_w.push_back(asm_word());
        exp_c.push_back(4);
        asm_q.delete();
      end else if (!out_full) begin
        out_full = 1;
        out_word = asm_word();
        asm_q.delete();
      end
    end
  endtask

  task automatic model_release();
    if (out_full) begin
      exp_w.push_back(out_word);
      exp_c.push_back(4);
      out_full = 0;
    end
    if (asm_q.size() == 4) begin
      exp_w.push_back(asm_word());
      exp_c.push_back(4);
      asm_q.delete();
    end
    stalled = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = $urandom();
    rx_data[7:0] = b;
    rx_load = 1'b1;
    tick(hold);
    rx_load = 1'b0;
    rx_data = $urandom();
    tick(gap);
    model_byte(b);
  endtask

  task automatic release_consumer();
    word_ready = 1'b1;
    tick(4);
    model_release();
  endtask

  task automatic drain(input string tag);
    int n;
    check({tag, "_count"}, got_w.size(), exp_w.size());
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_word"}, got_w[i], exp_w[i]);
      check({tag, "_cnt"}, got_c[i], exp_c[i]);
    end
    check({tag, "_overrun"}, ovr_seen, ovr_exp);
    got_w.delete();
    got_c.delete();
    exp_w.delete();
    exp_c.delete();
  endtask

  // Monitor on the falling edge: accepted words, overrun pulses, output stability.
  initial begin
    logic        pv, pr, prst;
    logic [31:0] pw;
    logic [2:0]  pc;
    pv = 0; pr = 0; prst = 0; pw = '0; pc = '0;
    forever begin
      @(negedge clk);
      if (reset && prst && pv && !pr) begin
        check("hold_valid", 32'(word_valid), 1);
        check("hold_word", word_out, pw);
        check("hold_cnt", 32'(byte_cnt), 32'(pc));
      end
      if (reset && word_valid && word_ready) begin
        got_w.push_back(word_out);
        got_c.push_back(int'(byte_cnt));
        $display("xfer word=%h byte_cnt=%0d", word_out, byte_cnt);
      end
      if (word_valid) valid_cycles++;
      if (overrun) ovr_seen++;
      pv = word_valid; pr = word_ready; prst = reset; pw = word_out; pc = byte_cnt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] w_exp;
    int          vc0, n;

    // Reset state
    tick(3);
    check("rst_word_out", word_out, 0);
    check("rst_word_valid", 32'(word_valid), 0);
    check("rst_byte_cnt", 32'(byte_cnt), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b1;
    word_ready = 1'b1;
    tick(2);

    // Four bytes straight through
    vc0 = valid_cycles;
    send_byte(8'h11, 1, 2);
    send_byte(8'h22, 2, 2);
    send_byte(8'h33, 1, 3);
    send_byte(8'h44, 1, 3);
    check("t1_valid_cycles", valid_cycles - vc0, 1);
    drain("t1");

    // Long rx_load level captures exactly one byte
    send_byte(8'hA5, 30, 2);
    check("t2_no_word", got_w.size(), 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 1 + (i * 7), 2);
    drain("t2");

    // Stalled consumer: held word, full assembly, then overrun on the ninth byte
    word_ready = 1'b0;
    stalled = 1;
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 2, 2);
    check("t3_valid", 32'(word_valid), 1);
    check("t3_word", word_out, 32'h04030201);
    check("t3_cnt", 32'(byte_cnt), 4);
    release_consumer();
    drain("t3");

    // Handshake in the same cycle as the fourth-byte transfer
    word_ready = 1'b0;
    stalled = 1;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom()), 1, 2);
    b = 8'($urandom());
    model_byte(b);
    w_exp = asm_word();
    rx_data = $urandom();
    rx_data[7:0] = b;
    rx_load = 1'b1;
    word_ready = 1'b1;
    tick(1);
    check("t4_valid_kept", 32'(word_valid), 1);
    check("t4_new_word", word_out, w_exp);
    model_release();
    rx_load = 1'b0;
    tick(2);
    check("t4_valid_clear", 32'(word_valid), 0);
    drain("t4");

    // Reset mid-word with a pending word; rx_load high across reset release
    word_ready = 1'b0;
    stalled = 1;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom()), 1, 2);
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_word_out", word_out, 0);
    check("t5_rst_valid", 32'(word_valid), 0);
    check("t5_rst_cnt", 32'(byte_cnt), 0);
    check("t5_rst_overrun", 32'(overrun), 0);
    asm_q.delete();
    out_full = 0;
    stalled = 0;
    tick(1);
    rx_data = 32'h1234_56AA;
    rx_load = 1'b1;
    word_ready = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    rx_load = 1'b0;
    tick(1);
    model_byte(8'hAA);
    send_byte(8'hBB, 1, 2);
    send_byte(8'hCC, 1, 2);
    send_byte(8'hDD, 1, 2);
    check("t5_last_word", word_out, 32'hDDCCBBAA);
    drain("t5");

    // Randomized phases, some with a stalled consumer
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 2) == 0) begin
        word_ready = 1'b0;
        stalled = 1;
        n = int'($urandom_range(1, 10));
        for (int i = 0; i < n; i++)
          send_byte(8'($urandom()), int'($urandom_range(1, 6)), int'($urandom_range(1, 3)));
        release_consumer();
      end else begin
        n = int'($urandom_range(1, 8));
        for (int i = 0; i < n; i++)
          send_byte(8'($urandom()), int'($urandom_range(1, 6)), int'($urandom_range(1, 3)));
      end
      drain("rand");
    end

    // Idle timeout on a partial word: restart from an empty assembly
    reset = 1'b0;
    tick(1);
    asm_q.delete();
    out_full = 0;
    reset = 1'b1;
    tick(1);
    send_byte(8'h5A, 1, 2);
    send_byte(8'hC3, 1, 2);
    for (int i = 0; i < 39; i++) begin
      enable = 1'b1;
      tick(1);
      enable = 1'b0;
      tick(2);
    end
    check("tmo_early", got_w.size(), 0);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(4);
`ifdef UART_RX_PACK_TIMEOUT_EN
    exp_w.push_back(asm_word());
    exp_c.push_back(asm_q.size());
    asm_q.delete();
    drain("tmo_flush");
`else
    drain("tmo_none");
    send_byte(8'h77, 1, 2);
    send_byte(8'h66, 1, 2);
    drain("tmo_held");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
